// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with byte-enabled writes, two
// combinational read ports and a self-clearing sequencer.
//
// Build option: define REGFILE_BYPASS_EN to forward an in-flight write to a
// matching read port in the same cycle. Without it, reads return the stored
// (pre-write) value.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset; restarts a full clear
//   we           write enable (ignored while busy)
//   wbe          per-byte write enables, bit i covers data [8i+7:8i]
//   regwriteaddr write address
//   regwritedata write data
//   rsaddr       read port A address
//   rtaddr       read port B address
//   rsdata       read port A data (combinational, zero while busy)
//   rtdata       read port B data (combinational, zero while busy)
//   clr_req      request to zero all entries
//   busy         high while the clear sequencer runs
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [ADDR_W-1:0]   regwriteaddr,
    input  logic [DATA_W-1:0]   regwritedata,
    input  logic [ADDR_W-1:0]   rsaddr,
    input  logic [ADDR_W-1:0]   rtaddr,
    output logic [DATA_W-1:0]   rsdata,
    output logic [DATA_W-1:0]   rtdata,
    input  logic                clr_req,
    output logic                busy
);

    localparam int unsigned    DEPTH    = 2 ** ADDR_W;
    localparam int unsigned    NBYTES   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_en;
    logic [DATA_W-1:0]   w_rs_raw;
    logic [DATA_W-1:0]   w_rt_raw;

    // Writes to entry 0 are dropped entirely when it is hard-wired to zero.
    assign w_wr_en = we && (r_state == ST_IDLE)
                     && !((ZERO_REG != 0) && (regwriteaddr == '0));

    assign busy = (r_state == ST_CLEAR);

    // Sequencer: reset forces a fresh clear from entry 0; clr_req is only
    // honoured from IDLE, so a request during a clear never restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage has no reset of its own; reset launches the clear sequence.
    // A write in the same cycle as clr_req lands first, then gets cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_en) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (wbe[b]) begin
                        r_mem[regwriteaddr][8*b +: 8] <= regwritedata[8*b +: 8];
                    end
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = stored;
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (addr == regwriteaddr)) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (wbe[b]) begin
                    v[8*b +: 8] = regwritedata[8*b +: 8];
                end
            end
        end
`endif
        if (busy || ((ZERO_REG != 0) && (addr == '0))) begin
            v = '0;
        end
        return v;
    endfunction

    assign w_rs_raw = r_mem[rsaddr];
    assign w_rt_raw = r_mem[rtaddr];

    always_comb begin
        rsdata = read_port(rsaddr, w_rs_raw);
        rtdata = read_port(rtaddr, w_rt_raw);
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  wbe;
    logic [4:0]  regwriteaddr;
    logic [31:0] regwritedata;
    logic [4:0]  rsaddr;
    logic [4:0]  rtaddr;
    logic        clr_req;
    logic [31:0] rsdata,  rtdata;
    logic [31:0] rsdata0, rtdata0;
    logic        busy, busy0;

    int errors = 0;
    int checks = 0;
    int cnt;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe),
        .regwriteaddr(regwriteaddr), .regwritedata(regwritedata),
        .rsaddr(rsaddr), .rtaddr(rtaddr),
        .rsdata(rsdata), .rtdata(rtdata),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe),
        .regwriteaddr(regwriteaddr), .regwritedata(regwritedata),
        .rsaddr(rsaddr), .rtaddr(rtaddr),
        .rsdata(rsdata0), .rtdata(rtdata0),
        .clr_req(clr_req), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; regwriteaddr = a; regwritedata = d; wbe = be;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wbe = '0; regwriteaddr = '0; regwritedata = '0;
        rsaddr = '0; rtaddr = '0; clr_req = 1'b0;

        // Reset for one cycle, then count busy cycles.
        tick();
        rst = 1'b0;
        rsaddr = 5'd9; rtaddr = 5'd20;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_rs_zero", rsdata, 32'h0);
        check("rst_rt_zero", rtdata, 32'h0);
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        check("rst_busy_cycles", cnt, 32'd32);
        check("rst_busy0_low", {31'b0, busy0}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rsaddr = 5'(i); rtaddr = 5'(31 - i);
            #1;
            check("post_rst_rs", rsdata, 32'h0);
            check("post_rst_rt", rtdata, 32'h0);
            check("post_rst_rs_z0", rsdata0, 32'h0);
        end

        // Byte-enabled merge on reg 5, then an all-zero wbe no-op.
        wr(5'd5, 32'hDEADBEEF, 4'b1111);
        wr(5'd5, 32'h00001200, 4'b0010);
        rsaddr = 5'd5; rtaddr = 5'd5;
        #1;
        check("merge_rs", rsdata, 32'hDEAD12EF);
        check("merge_rt", rtdata, 32'hDEAD12EF);
        wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        check("wbe0_noop", rsdata, 32'hDEAD12EF);

        // Entry 0 behaviour with and without the hard-wired zero.
        wr(5'd0, 32'h12345678, 4'b1111);
        rsaddr = 5'd0; rtaddr = 5'd0;
        #1;
        check("zr1_rs0", rsdata, 32'h0);
        check("zr1_rt0", rtdata, 32'h0);
        check("zr0_rs0", rsdata0, 32'h12345678);
        check("zr0_rt0", rtdata0, 32'h12345678);

        // Same-cycle read of an entry being written.
        wr(5'd7, 32'h00000077, 4'b1111);
        rsaddr = 5'd7; rtaddr = 5'd5;
        we = 1'b1; regwriteaddr = 5'd7; regwritedata = 32'hA5A5A5A5; wbe = 4'b1111;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_full_rs", rsdata, 32'hA5A5A5A5);
`else
        check("byp_full_rs", rsdata, 32'h00000077);
`endif
        check("byp_other_rt", rtdata, 32'hDEAD12EF);
        tick();
        we = 1'b0;
        check("after_full_rs", rsdata, 32'hA5A5A5A5);

        we = 1'b1; regwriteaddr = 5'd7; regwritedata = 32'h11223344; wbe = 4'b0001;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_part_rs", rsdata, 32'hA5A5A544);
`else
        check("byp_part_rs", rsdata, 32'hA5A5A5A5);
`endif
        tick();
        we = 1'b0;
        check("after_part_rs", rsdata, 32'hA5A5A544);

        // Bypass must never expose a write to hard-wired entry 0.
        rsaddr = 5'd0;
        we = 1'b1; regwriteaddr = 5'd0; regwritedata = 32'hCAFEF00D; wbe = 4'b1111;
        #1;
        check("byp_zr1_rs0", rsdata, 32'h0);
`ifdef REGFILE_BYPASS_EN
        check("byp_zr0_rs0", rsdata0, 32'hCAFEF00D);
`else
        check("byp_zr0_rs0", rsdata0, 32'h12345678);
`endif
        tick();
        we = 1'b0;

        // Write and clear request together; second request mid-clear ignored.
        wr(5'd3, 32'h00000011, 4'b1111);
        rsaddr = 5'd3; rtaddr = 5'd4;
        #1;
        check("pre_clr_r3", rsdata, 32'h00000011);
        we = 1'b1; regwriteaddr = 5'd4; regwritedata = 32'h00000022; wbe = 4'b1111;
        clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        check("clr_busy", {31'b0, busy}, 32'd1);
        check("clr_rs_zero", rsdata, 32'h0);
        cnt = 0;
        while (busy && cnt < 100) begin
            clr_req = (cnt == 10);
            tick();
            cnt++;
        end
        clr_req = 1'b0;
        check("clr_busy_cycles", cnt, 32'd32);
        #1;
        check("clr_r3", rsdata, 32'h0);
        check("clr_r4", rtdata, 32'h0);

        // Reset mid-clear restarts it; writes while busy are dropped.
        wr(5'd6, 32'h00000066, 4'b1111);
        rsaddr = 5'd6; rtaddr = 5'd6;
        #1;
        check("pre_rst_r6", rsdata, 32'h00000066);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 15) begin
            tick();
            cnt++;
        end
        check("mid_clr_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 20) begin
                we = 1'b1; regwriteaddr = 5'd6; regwritedata = 32'hFFFFFFFF; wbe = 4'b1111;
            end else begin
                we = 1'b0;
            end
            tick();
            cnt++;
        end
        we = 1'b0;
        check("rst_restart_cycles", cnt, 32'd32);
        #1;
        check("busy_write_dropped_rs", rsdata, 32'h0);
        check("busy_write_dropped_rt0", rtdata0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 we  in  1  write enable.
REQ-007 wbe  in  DATA_W/8  byte enables for the write; bit i covers data bits [8i+7:8i].
REQ-008 regwriteaddr  in  ADDR_W  write address.
REQ-009 regwritedata  in  DATA_W  write data.
REQ-010 rsaddr  in  ADDR_W  read port A address.
REQ-011 rtaddr  in  ADDR_W  read port B address.
REQ-012 rsdata  out  DATA_W  read port A data.
REQ-013 rtdata  out  DATA_W  read port B data.
REQ-014 clr_req  in  1  request to zero all entries.
REQ-015 busy  out  1  high while the clear sequencer runs.

Function
REQ-016 Reads SHALL be combinational: rsdata/rtdata reflect the addressed entry in the same cycle, zero latency.
REQ-017 Write SHALL occur at the rising edge when we=1 and busy=0; only bytes with wbe=1 change; wbe=0 on all bytes is a no-op.
REQ-018 With ZERO_REG=1, address 0 SHALL always read 0 on both ports and writes to it SHALL be discarded.
REQ-019 Clear sequencer SHALL have two states: IDLE and CLEAR, with an ADDR_W-bit pointer ptr.
REQ-020 In CLEAR, each rising edge SHALL write 0 to entry ptr and increment ptr; at ptr=DEPTH-1 it writes 0 and transitions to IDLE; ptr wrap to 0 is not retained as state.
REQ-021 busy SHALL equal (state==CLEAR); a full clear keeps busy high exactly DEPTH cycles.
REQ-022 In IDLE, clr_req=1 at a rising edge SHALL move to CLEAR with ptr=0; clr_req in CLEAR SHALL be ignored (no restart).
REQ-023 we=1 and clr_req=1 in the same IDLE cycle: write SHALL complete at that edge, then clearing starts and eventually zeroes it.
REQ-024 While busy=1, we SHALL be ignored and rsdata/rtdata SHALL read 0.
REQ-025 rsaddr==rtaddr SHALL return identical data on both ports.

Reset
REQ-026 rst=1 at a rising edge SHALL set state=CLEAR, ptr=0; busy SHALL be 1 during and after reset until the clear completes.
REQ-027 Reset SHALL take priority over clr_req and we; rst asserted mid-clear restarts the clear from ptr=0.
REQ-028 Output values during/after reset: busy=1, rsdata=rtdata=0 until busy falls.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when we=1, busy=0, and read address equals regwriteaddr (not entry 0 when ZERO_REG=1), that read port SHALL return the byte-merged new value combinationally in the same cycle.
REQ-030 REGFILE_BYPASS_EN undefined: read ports SHALL return the pre-write value until after the write edge.

Verification
REQ-031 rst 1 cycle, then idle; ADDR_W=5 -> busy high exactly 32 cycles after rst falls, all 32 entries read 0 afterwards.
REQ-032 Write 0xDEADBEEF to reg 5, wbe=4'b1111, then write 0x00001200 with wbe=4'b0010 -> reg 5 reads 0xDEAD12EF.
REQ-033 Write 0x12345678 to reg 0 with ZERO_REG=1 -> rsaddr=0 reads 0; with ZERO_REG=0 -> reads 0x12345678.
REQ-034 Write 0xA5A5A5A5 to reg 7 with rsaddr=7 same cycle -> rsdata=0xA5A5A5A5 pre-edge with REGFILE_BYPASS_EN, prior value without.
REQ-035 Fill reg 3=0x11, assert clr_req and we(reg 4=0x22) same cycle; pulse clr_req again at clear cycle 10 -> busy exactly 32 cycles, regs 3 and 4 read 0.
REQ-036 Assert rst at clear cycle 15, attempt write during busy -> clear restarts (busy 32 more cycles after rst falls), write ignored, entry reads 0.
